// File: rtl/fwrisc_trap_seq_pkg.sv
// Shared types and constants for the FWRISC trap sequencer.
package fwrisc_trap_pkg;

    localparam int unsigned XLEN      = 32;
    localparam int unsigned REG_ADDR_W = 6;
    localparam int unsigned CAUSE_W   = 4;

    // Sequencer states; WR_MTVAL is only reachable when FWRISC_TRAP_MTVAL_EN is defined
    typedef enum logic [2:0] {
        ST_IDLE      = 3'd0,
        ST_WR_MEPC   = 3'd1,
        ST_WR_MCAUSE = 3'd2,
        ST_WR_MTVAL  = 3'd3,
        ST_REDIRECT  = 3'd4
    } trap_state_e;

    // CSR slots in the 6-bit register-file address space (GPRs occupy 0..31)
    localparam logic [REG_ADDR_W-1:0] CSR_MTVEC  = 6'h25;
    localparam logic [REG_ADDR_W-1:0] CSR_MEPC   = 6'h29;
    localparam logic [REG_ADDR_W-1:0] CSR_MCAUSE = 6'h2A;
    localparam logic [REG_ADDR_W-1:0] CSR_MTVAL  = 6'h2B;

    // Machine external interrupt cause
    localparam logic [XLEN-1:0] MCAUSE_MEI = 32'h8000000B;

    // Synchronous exception cause: interrupt bit clear, code zero-extended
    function automatic logic [XLEN-1:0] exc_mcause(input logic [CAUSE_W-1:0] code);
        return {28'b0, code};
    endfunction

endpackage

// File: rtl/fwrisc_trap_seq_if.sv
// Core/register-file side signals of the trap sequencer.
// master = core + register file side, slave = the sequencer.
interface fwrisc_trap_seq_if;
    import fwrisc_trap_pkg::*;

    logic                  exc_req;
    logic [CAUSE_W-1:0]    exc_cause;
    logic [XLEN-1:0]       exc_pc;
    logic [XLEN-1:0]       exc_tval;
    logic                  exc_ack;
    logic                  mret_req;
    logic                  irq;
    logic                  meie;
    logic                  mie;
    logic [XLEN-1:0]       mtvec;
    logic                  instr_complete;
    logic [XLEN-1:0]       next_pc;
    logic [REG_ADDR_W-1:0] core_rd_waddr;
    logic [XLEN-1:0]       core_rd_wdata;
    logic                  core_rd_wen;
    logic [REG_ADDR_W-1:0] rd_waddr;
    logic [XLEN-1:0]       rd_wdata;
    logic                  rd_wen;
    logic                  trap;
    logic                  tret;
    logic                  stall;
    logic                  redirect_valid;
    logic [XLEN-1:0]       redirect_pc;

    modport master (
        output exc_req, exc_cause, exc_pc, exc_tval, mret_req, irq, meie, mie,
               mtvec, instr_complete, next_pc, core_rd_waddr, core_rd_wdata, core_rd_wen,
        input  exc_ack, rd_waddr, rd_wdata, rd_wen, trap, tret, stall,
               redirect_valid, redirect_pc
    );

    modport slave (
        input  exc_req, exc_cause, exc_pc, exc_tval, mret_req, irq, meie, mie,
               mtvec, instr_complete, next_pc, core_rd_waddr, core_rd_wdata, core_rd_wen,
        output exc_ack, rd_waddr, rd_wdata, rd_wen, trap, tret, stall,
               redirect_valid, redirect_pc
    );

endinterface

// File: rtl/fwrisc_trap_seq.sv
// Trap sequencer: serialises MEPC/MCAUSE(/MTVAL) writes through the single rd
// port on exception or interrupt, then redirects the PC; handles mret.
// Optional feature macro: FWRISC_TRAP_MTVAL_EN adds the MTVAL write state.
module fwrisc_trap_seq
    import fwrisc_trap_pkg::*;
#(
    parameter bit ENABLE_IRQ = 1'b1
) (
    input  logic              clock,
    input  logic              reset,
    fwrisc_trap_seq_if.slave  bus
);

    trap_state_e           state_q, state_d;
    logic [XLEN-1:0]       pc_q;
    logic [XLEN-1:0]       cause_q;
`ifdef FWRISC_TRAP_MTVAL_EN
    logic [XLEN-1:0]       tval_q;
`endif
    logic [XLEN-1:0]       shadow_q;
    logic                  is_mret_q;
    logic                  exc_ack_q;
    logic                  trap_q;
    logic                  tret_q;
    logic                  stall_q;
    logic                  redirect_valid_q;

    logic                  irq_take_c;
    logic                  idle_c;
    logic [REG_ADDR_W-1:0] rd_waddr_c;
    logic [XLEN-1:0]       rd_wdata_c;
    logic                  rd_wen_c;
    logic [XLEN-1:0]       redirect_pc_c;

    assign idle_c     = (state_q == ST_IDLE);
    assign irq_take_c = ENABLE_IRQ && bus.irq && bus.meie && bus.mie
                        && bus.instr_complete && !bus.exc_req;

    // Next-state decode; requests are only sampled in IDLE
    always_comb begin
        state_d = state_q;
        unique case (state_q)
            ST_IDLE: begin
                if (bus.exc_req || irq_take_c) begin
                    state_d = ST_WR_MEPC;
                end else if (bus.mret_req) begin
                    state_d = ST_REDIRECT;
                end
            end
            ST_WR_MEPC:   state_d = ST_WR_MCAUSE;
`ifdef FWRISC_TRAP_MTVAL_EN
            ST_WR_MCAUSE: state_d = ST_WR_MTVAL;
`else
            ST_WR_MCAUSE: state_d = ST_REDIRECT;
`endif
            ST_WR_MTVAL:  state_d = ST_REDIRECT;
            ST_REDIRECT:  state_d = ST_IDLE;
            default:      state_d = ST_IDLE;
        endcase
    end

    // State register, trap-context latches and registered pulse/stall outputs
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            state_q          <= ST_IDLE;
            pc_q             <= '0;
            cause_q          <= '0;
`ifdef FWRISC_TRAP_MTVAL_EN
            tval_q           <= '0;
`endif
            is_mret_q        <= 1'b0;
            exc_ack_q        <= 1'b0;
            trap_q           <= 1'b0;
            tret_q           <= 1'b0;
            stall_q          <= 1'b0;
            redirect_valid_q <= 1'b0;
        end else begin
            state_q          <= state_d;
            exc_ack_q        <= idle_c && bus.exc_req;
            trap_q           <= (state_d == ST_WR_MEPC);
            tret_q           <= idle_c && (state_d == ST_REDIRECT);
            stall_q          <= (state_d != ST_IDLE);
            redirect_valid_q <= (state_d == ST_REDIRECT);
            if (idle_c) begin
                is_mret_q <= (state_d == ST_REDIRECT);
                if (bus.exc_req) begin
                    pc_q    <= bus.exc_pc;
                    cause_q <= exc_mcause(bus.exc_cause);
`ifdef FWRISC_TRAP_MTVAL_EN
                    tval_q  <= bus.exc_tval;
`endif
                end else if (irq_take_c) begin
                    pc_q    <= bus.next_pc;
                    cause_q <= MCAUSE_MEI;
`ifdef FWRISC_TRAP_MTVAL_EN
                    tval_q  <= '0;
`endif
                end
            end
        end
    end

    // Write-port mux: core passthrough in IDLE, CSR writes during the sequence
    always_comb begin
        rd_waddr_c = '0;
        rd_wdata_c = '0;
        rd_wen_c   = 1'b0;
        unique case (state_q)
            ST_IDLE: begin
                rd_waddr_c = bus.core_rd_waddr;
                rd_wdata_c = bus.core_rd_wdata;
                rd_wen_c   = bus.core_rd_wen;
            end
            ST_WR_MEPC: begin
                rd_waddr_c = CSR_MEPC;
                rd_wdata_c = pc_q;
                rd_wen_c   = 1'b1;
            end
            ST_WR_MCAUSE: begin
                rd_waddr_c = CSR_MCAUSE;
                rd_wdata_c = cause_q;
                rd_wen_c   = 1'b1;
            end
`ifdef FWRISC_TRAP_MTVAL_EN
            ST_WR_MTVAL: begin
                rd_waddr_c = CSR_MTVAL;
                rd_wdata_c = tval_q;
                rd_wen_c   = 1'b1;
            end
`endif
            default: begin
                rd_wen_c   = 1'b0;
            end
        endcase
    end

    // MEPC shadow tracks every MEPC write, from the core or from the sequencer
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            shadow_q <= '0;
        end else if (rd_wen_c && (rd_waddr_c == CSR_MEPC)) begin
            shadow_q <= rd_wdata_c;
        end
    end

    // Redirect target; mtvec is read in the REDIRECT cycle itself
    always_comb begin
        redirect_pc_c = '0;
        if (state_q == ST_REDIRECT) begin
            redirect_pc_c = is_mret_q ? shadow_q : {bus.mtvec[31:2], 2'b00};
        end
    end

    assign bus.rd_waddr       = rd_waddr_c;
    assign bus.rd_wdata       = rd_wdata_c;
    assign bus.rd_wen         = rd_wen_c;
    assign bus.exc_ack        = exc_ack_q;
    assign bus.trap           = trap_q;
    assign bus.tret           = tret_q;
    assign bus.stall          = stall_q;
    assign bus.redirect_valid = redirect_valid_q;
    assign bus.redirect_pc    = redirect_pc_c;

endmodule

// File: tb/tb_fwrisc_trap_seq.sv
// Directed bench for fwrisc_trap_seq; expected latency follows FWRISC_TRAP_MTVAL_EN.
module tb_fwrisc_trap_seq;
    import fwrisc_trap_pkg::*;

    logic clock;
    logic reset;
    int   n_cmp;
    int   n_err;

    fwrisc_trap_seq_if bus();

    fwrisc_trap_seq #(.ENABLE_IRQ(1'b1)) dut (
        .clock (clock),
        .reset (reset),
        .bus   (bus)
    );

    initial clock = 1'b0;
    always #5 clock = ~clock;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clock);
        #1;
    endtask

    // Checks the registered outputs plus the write port as one group
    task automatic chk_out(input string tag, input logic ack, input logic trp, input logic trt,
                           input logic stl, input logic rv, input logic [31:0] rpc,
                           input logic wen, input logic [5:0] wa, input logic [31:0] wd);
        chk({tag, ".exc_ack"}, 32'(bus.exc_ack), 32'(ack));
        chk({tag, ".trap"}, 32'(bus.trap), 32'(trp));
        chk({tag, ".tret"}, 32'(bus.tret), 32'(trt));
        chk({tag, ".stall"}, 32'(bus.stall), 32'(stl));
        chk({tag, ".redirect_valid"}, 32'(bus.redirect_valid), 32'(rv));
        chk({tag, ".redirect_pc"}, bus.redirect_pc, rpc);
        chk({tag, ".rd_wen"}, 32'(bus.rd_wen), 32'(wen));
        if (wen) begin
            chk({tag, ".rd_waddr"}, 32'(bus.rd_waddr), 32'(wa));
            chk({tag, ".rd_wdata"}, bus.rd_wdata, wd);
        end
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog");
    end

    initial begin
        n_cmp = 0;
        n_err = 0;
        reset = 1'b1;
        bus.exc_req = 0; bus.exc_cause = '0; bus.exc_pc = '0; bus.exc_tval = '0;
        bus.mret_req = 0; bus.irq = 0; bus.meie = 0; bus.mie = 0; bus.mtvec = '0;
        bus.instr_complete = 0; bus.next_pc = '0;
        bus.core_rd_waddr = '0; bus.core_rd_wdata = '0; bus.core_rd_wen = 0;
        #3;
        chk_out("reset", 0, 0, 0, 0, 0, 32'h0, 0, 6'd0, 32'h0);
        #9 reset = 1'b0;
        tick();

        // Core writeback passes straight through in IDLE
        bus.core_rd_waddr = 6'd5; bus.core_rd_wdata = 32'hDEADBEEF; bus.core_rd_wen = 1;
        #1;
        chk_out("pass", 0, 0, 0, 0, 0, 32'h0, 1, 6'd5, 32'hDEADBEEF);
        tick();

        // Exception with a simultaneous mret; core write in the accept cycle still lands
        bus.mtvec = 32'h803;
        bus.exc_req = 1; bus.exc_cause = 4'd2; bus.exc_pc = 32'h100; bus.exc_tval = 32'h55;
        bus.mret_req = 1;
        bus.core_rd_waddr = 6'd7; bus.core_rd_wdata = 32'h11; bus.core_rd_wen = 1;
        #1;
        chk_out("exc.accept", 0, 0, 0, 0, 0, 32'h0, 1, 6'd7, 32'h11);
        tick();
        bus.exc_req = 0; bus.mret_req = 0;
        bus.core_rd_waddr = 6'd3; bus.core_rd_wdata = 32'h77;   // must be ignored while busy
        #1;
        chk_out("exc.mepc", 1, 1, 0, 1, 0, 32'h0, 1, CSR_MEPC, 32'h100);
        tick();
        chk_out("exc.mcause", 0, 0, 0, 1, 0, 32'h0, 1, CSR_MCAUSE, 32'h2);
`ifdef FWRISC_TRAP_MTVAL_EN
        tick();
        chk_out("exc.mtval", 0, 0, 0, 1, 0, 32'h0, 1, CSR_MTVAL, 32'h55);
`endif
        tick();
        chk_out("exc.redirect", 0, 0, 0, 1, 1, 32'h800, 0, 6'd0, 32'h0);
        bus.core_rd_wen = 0;
        tick();
        chk_out("exc.idle", 0, 0, 0, 0, 0, 32'h0, 0, 6'd0, 32'h0);

        // mret returns to the MEPC written by the exception
        bus.mret_req = 1;
        tick();
        bus.mret_req = 0;
        chk_out("mret1.redirect", 0, 0, 1, 1, 1, 32'h100, 0, 6'd0, 32'h0);
        tick();
        chk_out("mret1.idle", 0, 0, 0, 0, 0, 32'h0, 0, 6'd0, 32'h0);

        // Core software write to MEPC updates the shadow used by mret
        bus.core_rd_waddr = CSR_MEPC; bus.core_rd_wdata = 32'h300; bus.core_rd_wen = 1;
        tick();
        bus.core_rd_wen = 0;
        bus.mret_req = 1;
        tick();
        bus.mret_req = 0;
        chk_out("mret2.redirect", 0, 0, 1, 1, 1, 32'h300, 0, 6'd0, 32'h0);
        tick();

        // Interrupt with mie=0 is not taken
        bus.irq = 1; bus.meie = 1; bus.mie = 0; bus.instr_complete = 1; bus.next_pc = 32'h204;
        tick();
        chk_out("irq.masked", 0, 0, 0, 0, 0, 32'h0, 0, 6'd0, 32'h0);

        // Interrupt taken; mtvec rewritten in the accept cycle is honoured
        bus.mie = 1;
        bus.mtvec = 32'h1001;
        tick();
        bus.irq = 0; bus.instr_complete = 0; bus.mie = 0;
        chk_out("irq.mepc", 0, 1, 0, 1, 0, 32'h0, 1, CSR_MEPC, 32'h204);
        tick();
        chk_out("irq.mcause", 0, 0, 0, 1, 0, 32'h0, 1, CSR_MCAUSE, 32'h8000000B);
`ifdef FWRISC_TRAP_MTVAL_EN
        tick();
        chk_out("irq.mtval", 0, 0, 0, 1, 0, 32'h0, 1, CSR_MTVAL, 32'h0);
`endif
        tick();
        chk_out("irq.redirect", 0, 0, 0, 1, 1, 32'h1000, 0, 6'd0, 32'h0);
        tick();
        chk_out("irq.idle", 0, 0, 0, 0, 0, 32'h0, 0, 6'd0, 32'h0);

        // Reset during WR_MCAUSE abandons the sequence
        bus.exc_req = 1; bus.exc_cause = 4'd5; bus.exc_pc = 32'h400; bus.exc_tval = 32'h9;
        tick();
        bus.exc_req = 0;
        tick();
        chk_out("rst.pre", 0, 0, 0, 1, 0, 32'h0, 1, CSR_MCAUSE, 32'h5);
        #2 reset = 1'b1;
        #1;
        chk_out("rst.async", 0, 0, 0, 0, 0, 32'h0, 0, 6'd0, 32'h0);
        #2 reset = 1'b0;
        for (int i = 0; i < 5; i++) begin
            tick();
            chk("rst.no_redirect", 32'(bus.redirect_valid), 32'h0);
            chk("rst.no_stall", 32'(bus.stall), 32'h0);
        end

        // Shadow was cleared by reset, so mret now returns to 0
        bus.mret_req = 1;
        tick();
        bus.mret_req = 0;
        chk_out("rst.mret", 0, 0, 1, 1, 1, 32'h0, 0, 6'd0, 32'h0);
        tick();

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
